quad_decoder_param: RTL and testbench

- Parametrised quadrature encoder decoder for the wheel interface.
- Generalises the fixed 4-bit wheel counter with:
  - configurable count width;
  - 2-FF input synchronisation and a debounce filter;
  - selectable x1/x2/x4 resolution;
  - wrap or saturate counting;
  - sticky illegal-transition detection.
- Sits between the raw encoder pins A/B and the control logic that reads position and direction.

---
 rtl/quad_decoder_param.sv | 109 ++++++++++
 tb/tb_quad_decoder_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_param.sv
// Quadrature encoder decoder: 2-FF synchroniser, debounce filter, x1/x2/x4 decode,
// wrapping or saturating position counter and sticky illegal-transition flag.
module quad_decoder_param #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int SATURATE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             CW,
  output logic             CWW,
  output logic             step,
  output logic             err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);

  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     filt_ab;
  logic [FCW-1:0] fcnt;

  logic accept;
  logic legal;
  logic is_cw;
  logic counted;

  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                  input logic up);
    logic [WIDTH-1:0] r;
    if (up) begin
      r = (SATURATE != 0 && c == '1) ? c : c + WIDTH'(1);
    end else begin
      r = (SATURATE != 0 && c == '0) ? c : c - WIDTH'(1);
    end
    return r;
  endfunction

  // stage p0/p1: two-flop synchroniser, then debounce against the last accepted state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
      filt_ab <= 2'b00;
      fcnt    <= '0;
    end else begin
      sync_p0 <= {A, B};
      sync_p1 <= sync_p0;
      if (sync_p1 == filt_ab) begin
        fcnt <= '0;
      end else if (fcnt == FLAST) begin
        filt_ab <= sync_p1;
        fcnt    <= '0;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  always_comb begin
    accept  = (sync_p1 != filt_ab) && (fcnt == FLAST);
    legal   = ^(sync_p1 ^ filt_ab);
    is_cw   = 1'b0;
    case ({filt_ab, sync_p1})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: is_cw = 1'b1;
      default:                            is_cw = 1'b0;
    endcase
    case (mode)
      2'b00:   counted = legal & ~filt_ab[1] & sync_p1[1];
      2'b01:   counted = legal & (filt_ab[1] ^ sync_p1[1]);
      default: counted = legal;
    endcase
  end

  // stage p2: decode on the accept edge; clear overrides the count and flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      CW    <= 1'b0;
      CWW   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (accept && counted) begin
        CW  <= is_cw;
        CWW <= ~is_cw;
        if (!clear) begin
          count <= next_count(count, is_cw);
          step  <= 1'b1;
        end
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
      if (clear) begin
        count <= '0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder_param.sv
// Directed bench for quad_decoder_param: table of held encoder states plus
// hand sequences for latency, glitch, clear, wrap/saturate and async reset.
module tb_quad_decoder_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic [1:0] mode = 2'b10;
  logic       clear = 1'b0;

  logic [7:0] count;
  logic       cw, ccw, step, err;
  logic [3:0] count_w, count_s;
  logic       cw_w, ccw_w, step_w, err_w;
  logic       cw_s, ccw_s, step_s, err_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quad_decoder_param #(.WIDTH(8), .FILTER_LEN(4), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode), .clear(clear),
    .count(count), .CW(cw), .CWW(ccw), .step(step), .err(err));

  quad_decoder_param #(.WIDTH(4), .FILTER_LEN(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode), .clear(clear),
    .count(count_w), .CW(cw_w), .CWW(ccw_w), .step(step_w), .err(err_w));

  quad_decoder_param #(.WIDTH(4), .FILTER_LEN(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .A(A), .B(B), .mode(mode), .clear(clear),
    .count(count_s), .CW(cw_s), .CWW(ccw_s), .step(step_s), .err(err_s));

  typedef struct {
    logic [1:0] ab;
    logic [1:0] mode;
    int         cnt;
    int         cw;
    int         ccw;
    int         err;
    int         steps;
  } vec_t;

  vec_t vecs[40];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n, output int s_main, output int s_w, output int s_s);
    s_main = 0;
    s_w    = 0;
    s_s    = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (step)   s_main++;
      if (step_w) s_w++;
      if (step_s) s_s++;
    end
  endtask

  task automatic apply_row(input int i);
    int sm, sw, ss;
    @(negedge clk);
    {A, B} = vecs[i].ab;
    mode   = vecs[i].mode;
    hold(8, sm, sw, ss);
    check($sformatf("row%0d_count", i), int'(count), vecs[i].cnt);
    check($sformatf("row%0d_cw", i),    int'(cw),    vecs[i].cw);
    check($sformatf("row%0d_ccw", i),   int'(ccw),   vecs[i].ccw);
    check($sformatf("row%0d_err", i),   int'(err),   vecs[i].err);
    check($sformatf("row%0d_steps", i), sm,          vecs[i].steps);
  endtask

  initial begin
    int sm, sw, ss;

    // x4 CW: remainder of two cycles after the first 00->10 step
    vecs[0]  = '{2'b11, 2'b10, 2, 1, 0, 0, 1};
    vecs[1]  = '{2'b01, 2'b10, 3, 1, 0, 0, 1};
    vecs[2]  = '{2'b00, 2'b10, 4, 1, 0, 0, 1};
    vecs[3]  = '{2'b10, 2'b10, 5, 1, 0, 0, 1};
    vecs[4]  = '{2'b11, 2'b10, 6, 1, 0, 0, 1};
    vecs[5]  = '{2'b01, 2'b10, 7, 1, 0, 0, 1};
    vecs[6]  = '{2'b00, 2'b10, 8, 1, 0, 0, 1};
    // x4 CCW, two cycles
    vecs[7]  = '{2'b01, 2'b10, 7, 0, 1, 0, 1};
    vecs[8]  = '{2'b11, 2'b10, 6, 0, 1, 0, 1};
    vecs[9]  = '{2'b10, 2'b10, 5, 0, 1, 0, 1};
    vecs[10] = '{2'b00, 2'b10, 4, 0, 1, 0, 1};
    vecs[11] = '{2'b01, 2'b10, 3, 0, 1, 0, 1};
    vecs[12] = '{2'b11, 2'b10, 2, 0, 1, 0, 1};
    vecs[13] = '{2'b10, 2'b10, 1, 0, 1, 0, 1};
    vecs[14] = '{2'b00, 2'b10, 0, 0, 1, 0, 1};
    // x1 CW, three cycles: only 00->10 counts
    vecs[15] = '{2'b10, 2'b00, 1, 1, 0, 0, 1};
    vecs[16] = '{2'b11, 2'b00, 1, 1, 0, 0, 0};
    vecs[17] = '{2'b01, 2'b00, 1, 1, 0, 0, 0};
    vecs[18] = '{2'b00, 2'b00, 1, 1, 0, 0, 0};
    vecs[19] = '{2'b10, 2'b00, 2, 1, 0, 0, 1};
    vecs[20] = '{2'b11, 2'b00, 2, 1, 0, 0, 0};
    vecs[21] = '{2'b01, 2'b00, 2, 1, 0, 0, 0};
    vecs[22] = '{2'b00, 2'b00, 2, 1, 0, 0, 0};
    vecs[23] = '{2'b10, 2'b00, 3, 1, 0, 0, 1};
    vecs[24] = '{2'b11, 2'b00, 3, 1, 0, 0, 0};
    vecs[25] = '{2'b01, 2'b00, 3, 1, 0, 0, 0};
    vecs[26] = '{2'b00, 2'b00, 3, 1, 0, 0, 0};
    // x2 CW, three cycles: 00->10 and 11->01 count
    vecs[27] = '{2'b10, 2'b01, 4, 1, 0, 0, 1};
    vecs[28] = '{2'b11, 2'b01, 4, 1, 0, 0, 0};
    vecs[29] = '{2'b01, 2'b01, 5, 1, 0, 0, 1};
    vecs[30] = '{2'b00, 2'b01, 5, 1, 0, 0, 0};
    vecs[31] = '{2'b10, 2'b01, 6, 1, 0, 0, 1};
    vecs[32] = '{2'b11, 2'b01, 6, 1, 0, 0, 0};
    vecs[33] = '{2'b01, 2'b01, 7, 1, 0, 0, 1};
    vecs[34] = '{2'b00, 2'b01, 7, 1, 0, 0, 0};
    vecs[35] = '{2'b10, 2'b01, 8, 1, 0, 0, 1};
    vecs[36] = '{2'b11, 2'b01, 8, 1, 0, 0, 0};
    vecs[37] = '{2'b01, 2'b01, 9, 1, 0, 0, 1};
    vecs[38] = '{2'b00, 2'b01, 9, 1, 0, 0, 0};
    // illegal 00->11
    vecs[39] = '{2'b11, 2'b01, 9, 1, 0, 1, 0};

    #100;
    check("rst_count", int'(count), 0);
    check("rst_cw",    int'(cw),    0);
    check("rst_ccw",   int'(ccw),   0);
    check("rst_step",  int'(step),  0);
    check("rst_err",   int'(err),   0);
    #100;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // first step lands on the 6th edge after the change
    @(negedge clk);
    A = 1'b1;
    B = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_edge%0d_step", e), int'(step), (e == 6) ? 1 : 0);
    end
    check("lat_count", int'(count), 1);
    check("lat_cw",    int'(cw),    1);

    for (int i = 0; i < 39; i++) apply_row(i);

    // 2-cycle glitch on A is rejected
    @(negedge clk);
    A = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    A = 1'b0;
    hold(8, sm, sw, ss);
    check("glitch_steps", sm, 0);
    check("glitch_count", int'(count), 9);

    apply_row(39);

    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_count", int'(count), 0);
    check("clear_err",   int'(err),   0);
    check("clear_cw",    int'(cw),    1);
    check("clear_wcount", int'(count_w), 0);
    check("clear_scount", int'(count_s), 0);
    @(negedge clk);
    clear = 1'b0;

    // one CCW x4 step below zero: 11->10
    @(negedge clk);
    mode = 2'b10;
    A = 1'b1;
    B = 1'b0;
    hold(8, sm, sw, ss);
    check("wrap8_count", int'(count),   255);
    check("wrap4_count", int'(count_w), 15);
    check("wrap4_ccw",   int'(ccw_w),   1);
    check("wrap4_steps", sw,            1);
    check("sat_count",   int'(count_s), 0);
    check("sat_ccw",     int'(ccw_s),   1);
    check("sat_cw",      int'(cw_s),    0);
    check("sat_steps",   ss,            1);

    @(negedge clk);
    A = 1'b0;
    hold(8, sm, sw, ss);
    check("pre_rst_count", int'(count), 254);

    // async reset mid-filter, between edges
    @(negedge clk);
    A = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_cw",    int'(cw),    0);
    check("arst_ccw",   int'(ccw),   0);
    check("arst_step",  int'(step),  0);
    check("arst_err",   int'(err),   0);
    check("arst_wcount", int'(count_w), 0);
    @(negedge clk);
    reset = 1'b0;
    hold(8, sm, sw, ss);
    check("resume_count", int'(count), 1);
    check("resume_cw",    int'(cw),    1);
    check("resume_steps", sm,          1);
    @(negedge clk);
    B = 1'b1;
    hold(8, sm, sw, ss);
    check("resume2_count", int'(count), 2);

    // clear coinciding with an accept edge: no step, direction still updates
    @(negedge clk);
    A = 1'b0;
    B = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clrstep_step",  int'(step),  0);
    check("clrstep_count", int'(count), 0);
    check("clrstep_cw",    int'(cw),    1);
    check("clrstep_ccw",   int'(ccw),   0);
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
